// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types and helpers for the load/store aligner
package mem_access_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'd0,
    SIZE_HALF  = 2'd1,
    SIZE_WORD  = 2'd2,
    SIZE_DWORD = 2'd3
  } access_size_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } aligner_state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/lane_mask_gen.sv
// rtl/lane_mask_gen.sv - byte-lane mask over two adjacent words for a sized access
module lane_mask_gen
  import mem_access_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  parameter int OFF_W      = $clog2(WORD_BYTES)
) (
  input  logic [1:0]              size,
  input  logic [OFF_W-1:0]        offset,
  output logic [2*WORD_BYTES-1:0] lanes
);

  int nb;
  int off;

  // Range compare per lane avoids the overflow of (1 << nbytes) when nbytes == 2*WORD_BYTES.
  always_comb begin
    nb  = int'(size_bytes(size));
    off = int'(offset);
    for (int i = 0; i < 2*WORD_BYTES; i++) begin
      lanes[i] = (i >= off) && (i < off + nb);
    end
  end

endmodule

// File: rtl/mem_access_aligner.sv
// rtl/mem_access_aligner.sv - LSU access aligner issuing byte-enabled word beats
// Define MEM_MISALIGNED_SPLIT_EN to split word-crossing accesses into two beats.
module mem_access_aligner
  import mem_access_pkg::*;
#(
  parameter  int WORD_BYTES = 4,
  parameter  int ADDR_WIDTH = 32,
  localparam int WORD_BITS  = 8*WORD_BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [WORD_BITS-1:0]  req_data,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_BYTES-1:0] mem_byte_en,
  output logic [WORD_BITS-1:0]  mem_wdata,
  input  logic [WORD_BITS-1:0]  mem_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WORD_BITS-1:0]  rsp_data,
  output logic                  rsp_err
);

  localparam int OFF_W = $clog2(WORD_BYTES);

  aligner_state_t state;

  logic [OFF_W-1:0]        off_q;
  access_size_t            size_q;
  logic                    we_q;
  logic                    uns_q;

  logic [OFF_W-1:0]        req_off;
  logic [2*WORD_BYTES-1:0] req_lanes;
  logic [WORD_BITS-1:0]    req_wdata0;
  logic                    req_err;

  logic [WORD_BITS-1:0]    merged;
  logic [WORD_BITS-1:0]    load_result;
  logic                    sign;
  int                      nb;

`ifdef MEM_MISALIGNED_SPLIT_EN
  logic [WORD_BYTES-1:0]   lanes_hi_q;
  logic [WORD_BITS-1:0]    wdata1_q;
  logic [WORD_BITS-1:0]    rdata0_q;
  logic [WORD_BITS-1:0]    req_wdata1;
`endif

  assign req_off   = req_addr[OFF_W-1:0];
  assign req_ready = (state == ST_IDLE) && !rst;

  lane_mask_gen #(.WORD_BYTES(WORD_BYTES), .OFF_W(OFF_W)) u_lane_mask (
    .size  (req_size),
    .offset(req_off),
    .lanes (req_lanes)
  );

  // Store data is shifted into its lanes; bytes beyond the access size are zeroed.
  always_comb begin
    req_wdata0 = req_data << (8*req_off);
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (!req_lanes[i]) req_wdata0[8*i +: 8] = '0;
    end
`ifdef MEM_MISALIGNED_SPLIT_EN
    req_wdata1 = req_data >> (8*(WORD_BYTES - int'(req_off)));
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (!req_lanes[WORD_BYTES+i]) req_wdata1[8*i +: 8] = '0;
    end
`endif
  end

`ifdef MEM_MISALIGNED_SPLIT_EN
  assign req_err = int'(size_bytes(req_size)) > WORD_BYTES;
`else
  assign req_err = (int'(size_bytes(req_size)) > WORD_BYTES) ||
                   (|req_lanes[2*WORD_BYTES-1:WORD_BYTES]);
`endif

  // Merge the returned beat(s), right-align, then mask and extend to the access size.
  always_comb begin
`ifdef MEM_MISALIGNED_SPLIT_EN
    if (state == ST_BEAT1) merged = WORD_BITS'({mem_rdata, rdata0_q} >> (8*off_q));
    else                   merged = mem_rdata >> (8*off_q);
`else
    merged = mem_rdata >> (8*off_q);
`endif
    nb   = int'(size_bytes(size_q));
    sign = 1'b0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (b == nb - 1) sign = merged[8*b+7];
    end
    sign = sign && !uns_q;
    for (int b = 0; b < WORD_BYTES; b++) begin
      load_result[8*b +: 8] = (b < nb) ? merged[8*b +: 8] : {8{sign}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      off_q       <= '0;
      size_q      <= SIZE_BYTE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      mem_valid   <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_byte_en <= '0;
      mem_wdata   <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
`ifdef MEM_MISALIGNED_SPLIT_EN
      lanes_hi_q  <= '0;
      wdata1_q    <= '0;
      rdata0_q    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            off_q  <= req_off;
            size_q <= access_size_t'(req_size);
            we_q   <= req_we;
            uns_q  <= req_unsigned;
`ifdef MEM_MISALIGNED_SPLIT_EN
            lanes_hi_q <= req_lanes[2*WORD_BYTES-1:WORD_BYTES];
            wdata1_q   <= req_wdata1;
`endif
            if (req_err) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end else begin
              state       <= ST_BEAT0;
              mem_valid   <= 1'b1;
              mem_we      <= req_we;
              mem_addr    <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
              mem_byte_en <= req_lanes[WORD_BYTES-1:0];
              mem_wdata   <= req_wdata0;
            end
          end
        end
        ST_BEAT0: begin
          if (mem_ready) begin
`ifdef MEM_MISALIGNED_SPLIT_EN
            if (|lanes_hi_q) begin
              state       <= ST_BEAT1;
              rdata0_q    <= mem_rdata;
              mem_addr    <= mem_addr + ADDR_WIDTH'(WORD_BYTES);
              mem_byte_en <= lanes_hi_q;
              mem_wdata   <= wdata1_q;
            end else
`endif
            begin
              state     <= ST_RESP;
              mem_valid <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_data  <= we_q ? '0 : load_result;
            end
          end
        end
`ifdef MEM_MISALIGNED_SPLIT_EN
        ST_BEAT1: begin
          if (mem_ready) begin
            state     <= ST_RESP;
            mem_valid <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= we_q ? '0 : load_result;
          end
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
